// File: rtl/threshold_integrator_ctrl_pkg.sv
// Shared state and fault encodings for the threshold_integrator sequencer.
// Supervisors import this package to decode state_out and fault_code.
package threshold_integrator_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_RELEASE    = 3'd1,
      S_WAIT_SETUP = 3'd2,
      S_ARMED      = 3'd3,
      S_FAULT      = 3'd4
   } ctrl_state_e;

   typedef enum logic [2:0] {
      F_NONE          = 3'd0,
      F_BAD_CFG       = 3'd1,
      F_SETUP_TIMEOUT = 3'd2,
      F_OVER_THRESH   = 3'd3,
      F_FIFO_OVF      = 3'd4,
      F_FIFO_UNF      = 3'd5
   } fault_e;

   localparam logic [15:0] TRIP_MAX = 16'hFFFF;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // Simultaneous integrator faults resolve over_threshold > overflow > underflow.
   function automatic fault_e fault_sel(input logic over_thr, input logic ovf, input logic unf);
      if (over_thr) return F_OVER_THRESH;
      if (ovf)      return F_FIFO_OVF;
      if (unf)      return F_FIFO_UNF;
      return F_NONE;
   endfunction

endpackage

// File: rtl/threshold_integrator_ctrl.sv
// Sequencer for one threshold_integrator: validates config, releases and enables
// the integrator, supervises its fault outputs and latches the first fault.
module threshold_integrator_ctrl
   import threshold_integrator_ctrl_pkg::*;
#(
   parameter int unsigned RELEASE_CYCLES = 16,
   parameter int unsigned SETUP_TIMEOUT  = 1000000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        arm,
   input  logic        disarm,
   input  logic [31:0] window_cfg,
   input  logic [14:0] threshold_cfg,
   output logic        integ_rst,
   output logic        integ_enable,
   output logic [31:0] integ_window,
   output logic [14:0] integ_threshold,
   input  logic        integ_setup_done,
   input  logic        integ_over_threshold,
   input  logic        integ_err_overflow,
   input  logic        integ_err_underflow,
   output logic [2:0]  state_out,
   output logic [2:0]  fault_code,
   output logic        shutdown_req,
   output logic        armed,
   output logic [15:0] trip_count
);

   localparam int unsigned CNT_W = $clog2(max_u(RELEASE_CYCLES, SETUP_TIMEOUT) + 1);
   localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(SETUP_TIMEOUT - 1);

   ctrl_state_e      state_q, state_d;
   fault_e           code_q, code_d;
   fault_e           fault_in;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cfg_valid;
   logic             cfg_load;
   logic             trip_event;
   logic             shutdown_d;

   assign cfg_valid = (|window_cfg[31:11]) && (|threshold_cfg);
   assign fault_in  = fault_sel(integ_over_threshold, integ_err_overflow, integ_err_underflow);

   always_comb begin
      state_d  = state_q;
      code_d   = code_q;
      cnt_d    = '0;
      cfg_load = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (arm && !disarm) begin
               cfg_load = 1'b1;
               if (cfg_valid) begin
                  state_d = S_RELEASE;
               end else begin
                  state_d = S_FAULT;
                  code_d  = F_BAD_CFG;
               end
            end
         end
         S_RELEASE: begin
            if (cnt_q == REL_LAST) begin
               state_d = S_WAIT_SETUP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WAIT_SETUP: begin
            if (fault_in != F_NONE) begin
               state_d = S_FAULT;
               code_d  = fault_in;
            end else if (integ_setup_done) begin
               state_d = S_ARMED;
            end else if (cnt_q == TO_LAST) begin
               state_d = S_FAULT;
               code_d  = F_SETUP_TIMEOUT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_ARMED: begin
            if (fault_in != F_NONE) begin
               state_d = S_FAULT;
               code_d  = fault_in;
            end
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            state_d = S_IDLE;
            code_d  = F_NONE;
         end
      endcase

      // Disarm overrides every transition above, including a fault on the same cycle.
      if (disarm && state_q != S_IDLE) begin
         state_d = S_IDLE;
         code_d  = F_NONE;
         cnt_d   = '0;
      end
   end

   assign trip_event = (state_d == S_FAULT) && (state_q != S_FAULT) &&
                       (code_d inside {F_OVER_THRESH, F_FIFO_OVF, F_FIFO_UNF});
   assign shutdown_d = (state_d == S_FAULT) && (code_d != F_NONE) && (code_d != F_BAD_CFG);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         code_q  <= F_NONE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         integ_rst    <= 1'b1;
         integ_enable <= 1'b0;
         armed        <= 1'b0;
         shutdown_req <= 1'b0;
      end else begin
         integ_rst    <= (state_d == S_IDLE);
         integ_enable <= (state_d == S_WAIT_SETUP) || (state_d == S_ARMED);
         armed        <= (state_d == S_ARMED);
         shutdown_req <= shutdown_d;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         integ_window    <= '0;
         integ_threshold <= '0;
      end else if (cfg_load) begin
         integ_window    <= window_cfg;
         integ_threshold <= threshold_cfg;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         trip_count <= '0;
      end else if (trip_event && trip_count != TRIP_MAX) begin
         trip_count <= trip_count + 16'd1;
      end
   end

   assign state_out  = state_q;
   assign fault_code = code_q;

endmodule

// File: tb/tb_threshold_integrator_ctrl.sv
// Randomized bench for threshold_integrator_ctrl against a cycle-level behavioural model,
// with directed scenarios pinned by literal expectations.
module tb_threshold_integrator_ctrl;

   localparam int unsigned RC = 16;
   localparam int unsigned ST = 100;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        arm = 1'b0, disarm = 1'b0;
   logic [31:0] window_cfg = '0;
   logic [14:0] threshold_cfg = '0;
   logic        integ_setup_done = 1'b0;
   logic        integ_over_threshold = 1'b0, integ_err_overflow = 1'b0, integ_err_underflow = 1'b0;
   logic        integ_rst, integ_enable, shutdown_req, armed;
   logic [31:0] integ_window;
   logic [14:0] integ_threshold;
   logic [2:0]  state_out, fault_code;
   logic [15:0] trip_count;

   int n_cmp = 0;
   int n_bad = 0;

   threshold_integrator_ctrl #(.RELEASE_CYCLES(RC), .SETUP_TIMEOUT(ST)) dut (
      .clk(clk), .resetn(resetn), .arm(arm), .disarm(disarm),
      .window_cfg(window_cfg), .threshold_cfg(threshold_cfg),
      .integ_rst(integ_rst), .integ_enable(integ_enable),
      .integ_window(integ_window), .integ_threshold(integ_threshold),
      .integ_setup_done(integ_setup_done), .integ_over_threshold(integ_over_threshold),
      .integ_err_overflow(integ_err_overflow), .integ_err_underflow(integ_err_underflow),
      .state_out(state_out), .fault_code(fault_code), .shutdown_req(shutdown_req),
      .armed(armed), .trip_count(trip_count)
   );

   always #5 clk = ~clk;

   // Behavioural model: phase number plus cycles remaining in the timed phases.
   int          m_phase = 0;
   int          m_left  = 0;
   int          m_code  = 0;
   int          m_trip  = 0;
   logic [31:0] m_win   = '0;
   logic [14:0] m_thr   = '0;

   function automatic int fault_of(input logic o, input logic v, input logic u);
      if (o) return 3;
      if (v) return 4;
      if (u) return 5;
      return 0;
   endfunction

   task automatic go_fault(input int code);
      m_phase = 4;
      m_code  = code;
      if (code >= 3 && m_trip < 65535) m_trip = m_trip + 1;
   endtask

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_phase = 0; m_left = 0; m_code = 0; m_trip = 0; m_win = '0; m_thr = '0;
      end else begin
         int f;
         f = fault_of(integ_over_threshold, integ_err_overflow, integ_err_underflow);
         if (m_phase != 0 && disarm) begin
            m_phase = 0;
            m_code  = 0;
         end else begin
            case (m_phase)
               0: if (arm && !disarm) begin
                     m_win = window_cfg;
                     m_thr = threshold_cfg;
                     if (window_cfg >= 32'd2048 && threshold_cfg != 0) begin
                        m_phase = 1;
                        m_left  = RC;
                     end else go_fault(1);
                  end
               1: begin
                     m_left = m_left - 1;
                     if (m_left == 0) begin
                        m_phase = 2;
                        m_left  = ST;
                     end
                  end
               2: if (f != 0) go_fault(f);
                  else if (integ_setup_done) m_phase = 3;
                  else begin
                     m_left = m_left - 1;
                     if (m_left == 0) go_fault(2);
                  end
               3: if (f != 0) go_fault(f);
               default: ;
            endcase
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #2;
      chk("m.state",     64'(state_out),       64'(m_phase));
      chk("m.integ_rst", 64'(integ_rst),       64'(m_phase == 0));
      chk("m.enable",    64'(integ_enable),    64'(m_phase == 2 || m_phase == 3));
      chk("m.armed",     64'(armed),           64'(m_phase == 3));
      chk("m.code",      64'(fault_code),      64'(m_code));
      chk("m.shutdown",  64'(shutdown_req),    64'(m_phase == 4 && m_code >= 2));
      chk("m.trip",      64'(trip_count),      64'(m_trip));
      chk("m.window",    64'(integ_window),    64'(m_win));
      chk("m.threshold", 64'(integ_threshold), 64'(m_thr));
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int setup_pct;
      // Reset state
      tick(3);
      chk("rst.state", 64'(state_out), 0);
      chk("rst.integ_rst", 64'(integ_rst), 1);
      chk("rst.enable", 64'(integ_enable), 0);
      chk("rst.window", 64'(integ_window), 0);
      chk("rst.trip", 64'(trip_count), 0);
      resetn = 1'b1;

      // Valid arm: release then enable 16 cycles later, then setup_done
      tick(1);
      window_cfg = 32'd4096; threshold_cfg = 15'd1000; arm = 1'b1;
      tick(1); arm = 1'b0;
      chk("arm.integ_rst", 64'(integ_rst), 0);
      chk("arm.state", 64'(state_out), 1);
      chk("arm.window", 64'(integ_window), 4096);
      chk("arm.thr", 64'(integ_threshold), 1000);
      tick(15);
      chk("rel.enable_lo", 64'(integ_enable), 0);
      tick(1);
      chk("rel.enable_hi", 64'(integ_enable), 1);
      chk("rel.state", 64'(state_out), 2);
      tick(4); integ_setup_done = 1'b1;
      tick(1); integ_setup_done = 1'b0;
      chk("setup.armed", 64'(armed), 1);
      chk("setup.code", 64'(fault_code), 0);

      // Simultaneous over_threshold + overflow
      integ_over_threshold = 1'b1; integ_err_overflow = 1'b1;
      tick(1); integ_over_threshold = 1'b0; integ_err_overflow = 1'b0;
      chk("ovt.state", 64'(state_out), 4);
      chk("ovt.code", 64'(fault_code), 3);
      chk("ovt.shutdown", 64'(shutdown_req), 1);
      chk("ovt.trip", 64'(trip_count), 1);
      disarm = 1'b1;
      tick(1); disarm = 1'b0;
      chk("dis.state", 64'(state_out), 0);
      chk("dis.integ_rst", 64'(integ_rst), 1);
      chk("dis.code", 64'(fault_code), 0);
      chk("dis.shutdown", 64'(shutdown_req), 0);
      chk("dis.trip", 64'(trip_count), 1);

      // Window below 2048 is rejected
      window_cfg = 32'd2047; arm = 1'b1;
      tick(1); arm = 1'b0;
      chk("bad.state", 64'(state_out), 4);
      chk("bad.code", 64'(fault_code), 1);
      chk("bad.shutdown", 64'(shutdown_req), 0);
      tick(3);
      chk("bad.enable", 64'(integ_enable), 0);
      disarm = 1'b1; tick(1); disarm = 1'b0;

      // arm and disarm together in IDLE
      window_cfg = 32'd4096; arm = 1'b1; disarm = 1'b1;
      tick(1); arm = 1'b0; disarm = 1'b0;
      chk("ad.state", 64'(state_out), 0);
      chk("ad.integ_rst", 64'(integ_rst), 1);

      // Setup timeout exactly ST cycles after WAIT_SETUP entry
      arm = 1'b1; tick(1); arm = 1'b0;
      tick(16);
      chk("to.wait", 64'(state_out), 2);
      tick(ST - 1);
      chk("to.still_wait", 64'(state_out), 2);
      tick(1);
      chk("to.state", 64'(state_out), 4);
      chk("to.code", 64'(fault_code), 2);
      chk("to.shutdown", 64'(shutdown_req), 1);
      chk("to.trip", 64'(trip_count), 1);
      disarm = 1'b1; tick(1); disarm = 1'b0;

      // Async reset while ARMED
      arm = 1'b1; tick(1); arm = 1'b0;
      tick(16); integ_setup_done = 1'b1;
      tick(1); integ_setup_done = 1'b0;
      chk("ar.armed", 64'(armed), 1);
      resetn = 1'b0;
      #1;
      chk("ar.integ_rst", 64'(integ_rst), 1);
      chk("ar.enable", 64'(integ_enable), 0);
      chk("ar.state", 64'(state_out), 0);
      chk("ar.trip", 64'(trip_count), 0);
      tick(1); resetn = 1'b1;

      // Randomized traffic
      setup_pct = 12;
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         if (i % 500 == 0) setup_pct = ($urandom_range(0, 2) == 0) ? 0 : 12;
         arm    = ($urandom_range(0, 19) == 0);
         disarm = ($urandom_range(0, 79) == 0);
         window_cfg = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2047))
                                                  : (($urandom_range(0, 1) == 0) ? 32'd2048 : $urandom);
         threshold_cfg = ($urandom_range(0, 7) == 0) ? 15'd0 : 15'($urandom);
         integ_setup_done     = ($urandom_range(0, 99) < setup_pct);
         integ_over_threshold = ($urandom_range(0, 99) == 0);
         integ_err_overflow   = ($urandom_range(0, 99) == 0);
         integ_err_underflow  = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 1999) == 0) begin
            resetn = 1'b0;
            @(negedge clk);
            resetn = 1'b1;
         end
      end
      @(negedge clk);
      arm = 1'b0; disarm = 1'b0; integ_setup_done = 1'b0;
      integ_over_threshold = 1'b0; integ_err_overflow = 1'b0; integ_err_underflow = 1'b0;
      tick(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
